// File: rtl/led_matrix_scan.sv
// Row-multiplexed 8x8 LED matrix driver with a double-buffered frame.
// The back buffer is written row by row; it is copied to the front buffer only at a frame boundary.
module led_matrix_scan #(
  parameter int ROW_CYCLES         = 27000,
  parameter int BLANK_CYCLES       = 270,
  parameter bit CATHODE_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       commit,
  output logic       commit_pending,
  output logic       frame_start,
  output logic [7:0] anode,
  output logic [7:0] cathode
);

  localparam int MAX_LOAD = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W    = (MAX_LOAD > 1) ? $clog2(MAX_LOAD) : 1;
  localparam logic [CNT_W-1:0] ROW_LOAD   = CNT_W'(ROW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [7:0] CATH_OFF = CATHODE_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic       CATH_POL = CATHODE_ACTIVE_LOW;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t           state_reg;
  logic [2:0]       row_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       back_reg  [8];
  logic [7:0]       front_reg [8];
  logic             commit_pending_reg;
  logic             frame_start_reg;
  logic [7:0]       anode_reg;
  logic [7:0]       cathode_reg;

  logic       wr_fire;
  logic       cnt_done;
  logic       frame_boundary;
  logic       swap;
  logic [7:0] front_row;
  logic [7:0] row_drive;

  assign wr_ready       = !commit_pending_reg;
  assign wr_fire        = wr_valid && !commit_pending_reg;
  assign cnt_done       = (cnt_reg == '0);
  assign frame_boundary = (state_reg == ST_ON) && cnt_done && (row_reg == 3'd7);
  assign swap           = frame_boundary && commit_pending_reg;

  // Board wiring mirrors the columns: pixel bit i drives cathode bit 7-i.
  assign front_row = front_reg[row_reg];
  for (genvar gi = 0; gi < 8; gi++) begin : g_col
    assign row_drive[7-gi] = front_row[gi] ^ CATH_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        back_reg[i]  <= '0;
        front_reg[i] <= '0;
      end
    end else begin
      if (wr_fire) begin
        back_reg[wr_row] <= wr_data;
      end
      if (swap) begin
        for (int i = 0; i < 8; i++) begin
          front_reg[i] <= back_reg[i];
        end
      end
    end
  end

  // A commit that arrives while one is already waiting is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_pending_reg <= 1'b0;
      frame_start_reg    <= 1'b0;
    end else begin
      frame_start_reg <= frame_boundary;
      if (swap) begin
        commit_pending_reg <= 1'b0;
      end else if (commit && !commit_pending_reg) begin
        commit_pending_reg <= 1'b1;
      end
    end
  end

  // Anode and cathode are loaded on the same edge as the state change,
  // so a lit row never carries stale column data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_BLANK;
      row_reg     <= 3'd0;
      cnt_reg     <= BLANK_LOAD;
      anode_reg   <= 8'h00;
      cathode_reg <= CATH_OFF;
    end else begin
      case (state_reg)
        ST_BLANK: begin
          if (cnt_done) begin
            state_reg   <= ST_ON;
            cnt_reg     <= ROW_LOAD;
            anode_reg   <= 8'h01 << row_reg;
            cathode_reg <= row_drive;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        ST_ON: begin
          if (cnt_done) begin
            state_reg   <= ST_BLANK;
            cnt_reg     <= BLANK_LOAD;
            row_reg     <= row_reg + 3'd1;
            anode_reg   <= 8'h00;
            cathode_reg <= CATH_OFF;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_reg   <= ST_BLANK;
          cnt_reg     <= BLANK_LOAD;
          anode_reg   <= 8'h00;
          cathode_reg <= CATH_OFF;
        end
      endcase
    end
  end

  assign commit_pending = commit_pending_reg;
  assign frame_start    = frame_start_reg;
  assign anode          = anode_reg;
  assign cathode        = cathode_reg;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan with a short scan (4-clock rows, 1-clock blanking, active-low cathodes).
module tb_led_matrix_scan;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       commit;
  logic       commit_pending;
  logic       frame_start;
  logic [7:0] anode;
  logic [7:0] cathode;

  led_matrix_scan #(
    .ROW_CYCLES(4),
    .BLANK_CYCLES(1),
    .CATHODE_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_row(wr_row),
    .wr_data(wr_data),
    .commit(commit),
    .commit_pending(commit_pending),
    .frame_start(frame_start),
    .anode(anode),
    .cathode(cathode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] row;
    logic [7:0] data;
    logic [7:0] anode;
    logic [7:0] cathode;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] exp_cath [8];
  int         tests;
  int         fails;
  int         ready_hi;
  int         fs_early;
  int         hot_bad;
  logic [7:0] prev_anode;

  // Watches for multi-hot anodes and for one lit row following another without a blank gap.
  initial begin
    hot_bad    = 0;
    prev_anode = 8'h00;
  end
  always @(negedge clk) begin
    if ($countones(anode) > 1) hot_bad <= hot_bad + 1;
    if (prev_anode != 8'h00 && anode != 8'h00 && anode != prev_anode) hot_bad <= hot_bad + 1;
    prev_anode <= anode;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  task automatic wait_anode(input bit nonzero, input string tag);
    for (int n = 0; n < 60; n++) begin
      if ((anode != 8'h00) == nonzero) return;
      @(negedge clk);
    end
    tests++;
    fails++;
    $display("FAIL %s_wait: anode got 0x%02h required lit=%0d within 60 cycles", tag, anode, nonzero);
  endtask

  task automatic wait_fs(input string tag, output int hi);
    hi = 0;
    for (int n = 0; n < 100; n++) begin
      if (frame_start === 1'b1) return;
      if (wr_ready) hi++;
      @(negedge clk);
    end
    tests++;
    fails++;
    $display("FAIL %s_fs: frame_start got none required a pulse within 100 cycles", tag);
  endtask

  task automatic check_rows(input string tag);
    for (int i = 0; i < 8; i++) begin
      wait_anode(1'b1, tag);
      check($sformatf("%s_anode_r%0d", tag, i), {24'd0, anode}, {24'd0, vecs[i].anode});
      check($sformatf("%s_cath_r%0d", tag, i), {24'd0, cathode}, {24'd0, exp_cath[i]});
      wait_anode(1'b0, tag);
    end
  endtask

  task automatic write_row(input logic [2:0] row, input logic [7:0] data);
    wr_valid = 1'b1;
    wr_row   = row;
    wr_data  = data;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    // Cathode = bit-reversed, inverted pixel byte.
    vecs[0] = '{3'd0, 8'h01, 8'h01, 8'h7F};
    vecs[1] = '{3'd1, 8'h00, 8'h02, 8'hFF};
    vecs[2] = '{3'd2, 8'h81, 8'h04, 8'h7E};
    vecs[3] = '{3'd3, 8'h3C, 8'h08, 8'hC3};
    vecs[4] = '{3'd4, 8'hF0, 8'h10, 8'hF0};
    vecs[5] = '{3'd5, 8'h0F, 8'h20, 8'h0F};
    vecs[6] = '{3'd6, 8'h12, 8'h40, 8'hB7};
    vecs[7] = '{3'd7, 8'hC0, 8'h80, 8'hFC};

    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_row   = 3'd0;
    wr_data  = 8'h00;
    commit   = 1'b0;

    // 1: reset state and first row timing
    repeat (3) @(negedge clk);
    check("t1_rst_anode", {24'd0, anode}, 32'h00);
    check("t1_rst_cathode", {24'd0, cathode}, 32'hFF);
    check("t1_rst_pending", {31'd0, commit_pending}, 32'd0);
    check("t1_rst_fs", {31'd0, frame_start}, 32'd0);
    check("t1_rst_ready", {31'd0, wr_ready}, 32'd1);
    rst_n    = 1'b1;
    fs_early = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        check($sformatf("t1_row0_anode_c%0d", k), {24'd0, anode}, 32'h01);
        check($sformatf("t1_row0_cath_c%0d", k), {24'd0, cathode}, 32'hFF);
      end
      if (k == 5) check("t1_blank_after_row0", {24'd0, anode}, 32'h00);
      if (k == 6) check("t1_row1_anode", {24'd0, anode}, 32'h02);
      if (k < 40 && frame_start) fs_early++;
      if (k == 40) check("t1_first_boundary_fs", {31'd0, frame_start}, 32'd1);
    end
    check("t1_no_fs_first_frame", fs_early, 0);

    // 2: write all rows, commit, view the new frame
    for (int i = 0; i < 8; i++) write_row(vecs[i].row, vecs[i].data);
    pulse_commit();
    check("t2_pending_set", {31'd0, commit_pending}, 32'd1);
    check("t2_ready_low", {31'd0, wr_ready}, 32'd0);
    wait_fs("t2", ready_hi);
    check("t2_ready_stayed_low", ready_hi, 0);
    check("t2_pending_clr", {31'd0, commit_pending}, 32'd0);
    check("t2_ready_rise", {31'd0, wr_ready}, 32'd1);
    @(negedge clk);
    check("t2_fs_one_cycle", {31'd0, frame_start}, 32'd0);
    for (int i = 0; i < 8; i++) exp_cath[i] = vecs[i].cathode;
    check_rows("t2");

    // 3: back buffer frozen while a commit waits
    pulse_commit();
    wr_valid = 1'b1;
    wr_row   = 3'd1;
    wr_data  = 8'hFF;
    check("t3_pending_set", {31'd0, commit_pending}, 32'd1);
    wait_fs("t3", ready_hi);
    check("t3_frozen_ready", ready_hi, 0);
    @(negedge clk);
    wr_valid = 1'b0;
    check_rows("t3_unchanged");
    pulse_commit();
    wait_fs("t3b", ready_hi);
    @(negedge clk);
    exp_cath[1] = 8'h00;
    check_rows("t3_after_commit");

    // 4: write and commit in the same cycle
    wr_valid = 1'b1;
    wr_row   = 3'd0;
    wr_data  = 8'hAA;
    commit   = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    commit   = 1'b0;
    check("t4_pending_set", {31'd0, commit_pending}, 32'd1);
    wait_fs("t4", ready_hi);
    @(negedge clk);
    exp_cath[0] = 8'hAA;
    check_rows("t4");

    // 5: second commit while pending is ignored
    pulse_commit();
    repeat (2) @(negedge clk);
    pulse_commit();
    check("t5_pending_set", {31'd0, commit_pending}, 32'd1);
    wait_fs("t5", ready_hi);
    check("t5_pending_fall", {31'd0, commit_pending}, 32'd0);
    write_row(3'd3, 8'h00);
    check("t5_no_rearm", {31'd0, commit_pending}, 32'd0);
    check_rows("t5");
    check("t5_still_clear", {31'd0, commit_pending}, 32'd0);

    // 6: reset during ON(r=4) with a commit waiting
    pulse_commit();
    for (int n = 0; n < 100; n++) begin
      if (anode == 8'h10) break;
      @(negedge clk);
    end
    check("t6_reached_row4", {24'd0, anode}, 32'h10);
    check("t6_pending_before", {31'd0, commit_pending}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_anode", {24'd0, anode}, 32'h00);
    check("t6_rst_cathode", {24'd0, cathode}, 32'hFF);
    check("t6_rst_pending", {31'd0, commit_pending}, 32'd0);
    check("t6_rst_ready", {31'd0, wr_ready}, 32'd1);
    check("t6_rst_fs", {31'd0, frame_start}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) exp_cath[i] = 8'hFF;
    check_rows("t6_blank");

    check("anode_one_hot_bracketed", hot_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
